fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the MIPS32 pipeline, directly upstream of the instruction memory. Owns the program counter and drives the memory's address and stall inputs. Re-aligns each one-cycle-latency memory response with the PC that requested it. Delivers {pc, inst, fault} to decode through a valid/ready handshake, using a 2-entry skid FIFO so no response is lost when decode stalls.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  fetch address presented to instruction memory (equals PC register)
- imem_stall  out  1  1 = no request this cycle (memory returns 0 next cycle)
- imem_rdata  in  32  instruction for the request issued in the previous cycle
- imem_err  in  1  error flag for the previous-cycle request
- redirect_valid  in  1  branch/jump/exception redirect, single-cycle pulse
- redirect_target  in  32  new PC when redirect_valid=1
- id_ready  in  1  decode accepts the current output this cycle
- if_valid  out  1  output entry valid
- if_pc  out  32  PC of output instruction (0 when if_valid=0)
- if_inst  out  32  instruction word (0 when if_valid=0 or fault)
- if_fault  out  1  fetch fault (misaligned PC or imem_err)

## Operation
- State: pc, resp_valid, resp_pc, resp_fault, 2-entry FIFO {pc, inst, fault} with count 0..2, and mode RUN/HALT.
- Issue: issue = !rst && mode==RUN && count==0 && !redirect_valid && pc[1:0]==0.
  - imem_stall = !issue.
  - On issue: resp_valid<=1, resp_pc<=pc, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Otherwise: resp_valid<=0 and pc is held.
- Response entry when resp_valid=1: {resp_pc, imem_rdata, imem_err}.
  - When imem_err=1, inst is forced to 0 and fault=1.
- Output select: count>0 drives the FIFO head; else resp_valid drives the response entry; else if_valid=0.
- Handshake:
  - Pop the FIFO head when count>0 && id_ready.
  - Push the response entry when resp_valid && !(count==0 && id_ready).
  - Push and pop may occur in the same cycle.
  - By construction count never exceeds 2; a push at count==2 is a design error.
- Fault: a delivered entry with fault=1 moves the mode to HALT at the handshake.
  - In HALT, no issue occurs; only a redirect leaves HALT.
- Redirect (highest priority, above push/pop/issue):
  - count<=0 and the FIFO is flushed.
  - Any response arriving next cycle is discarded, as is the response on the redirect cycle.
  - pc<=redirect_target; mode<=RUN.
  - if_valid=0 in the redirect cycle.
- Misaligned pc (pc[1:0]!=0, reachable only via redirect), with mode==RUN and count==0:
  - No memory request.
  - Inject a response entry {pc, 0, fault=1} as if issued; mode goes to HALT once it is delivered.

## Timing
- Reset, all registers in the cycle after rst is high: pc=RESET_PC, resp_valid=0, count=0, mode=RUN.
  - Outputs: imem_stall=1, if_valid=0, if_pc=0, if_inst=0, if_fault=0.
- First fetch: imem_addr=RESET_PC with imem_stall=0 in the first cycle after rst deasserts. if_valid=1 one cycle later.
- Steady state with id_ready=1: one instruction per cycle, latency 1 from issue to if_valid.
- Decode stall: the in-flight response and the one behind it land in the FIFO (count 2). Fetch resumes the cycle after count reaches 0, giving a 1-cycle bubble.
- Redirect at cycle t: imem_addr=target with imem_stall=0 at t+1; first if_valid at t+2. Redirect penalty is 2 cycles.
- rst mid-operation overrides redirect and handshake; in-flight data is dropped.

## Test plan
- Reset release with RESET_PC=0, id_ready=1, memory returning addr^32'hA5A5_A5A5 -> if_pc 0,4,8,... each cycle with matching if_inst; first if_valid 1 cycle after the first issue.
- id_ready held 0 for 5 cycles mid-stream at pc 0x10 -> count saturates at 2, imem_stall=1, no duplicate or lost PC; on release, 0x10, 0x14, 0x18 are delivered in order.
- redirect to 0x100 while count=2 and a response is in flight -> FIFO flushed, stale response dropped, next if_pc=0x100 exactly 2 cycles later.
- redirect to 0x102 -> one entry {pc=0x102, inst=0, fault=1}, no memory request, then fetch halted; a redirect to 0x200 resumes fetch.
- imem_err=1 on the response for 0x20 -> if_fault=1, if_inst=0, subsequent fetch halted.
- pc=32'hFFFF_FFF8 with sequential fetch -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; rst asserted with count=1 -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: signal bundle around the instruction-fetch stage.
//   imem_addr/imem_stall   fetch request to instruction memory
//   imem_rdata/imem_err    one-cycle-latency memory response
//   redirect_valid/target  single-cycle PC redirect from later stages
//   id_ready               decode accepts the current output
//   if_valid/pc/inst/fault entry delivered to decode
// Handshake: an entry transfers to decode in every cycle where
// if_valid=1 and id_ready=1. if_valid does not depend on id_ready, and
// the entry is held unchanged until it transfers (unless a redirect or
// reset flushes it).
// Modports: master = fetch stage, slave = memory/decode environment.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_stall;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_fault;

  modport master (
    output imem_addr, imem_stall, if_valid, if_pc, if_inst, if_fault,
    input  imem_rdata, imem_err, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_addr, imem_stall, if_valid, if_pc, if_inst, if_fault,
    output imem_rdata, imem_err, redirect_valid, redirect_target, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS32 instruction-fetch stage.
// Owns the PC, issues one request per cycle to a one-cycle-latency
// instruction memory, re-aligns the response with its PC and delivers
// {pc, inst, fault} to decode. A 2-entry skid FIFO absorbs the response
// in flight (and the one behind it) when decode stalls.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        fetch_unit_if.master (memory, redirect and decode signals)
//   dbg_halt   1 while the fetch mode FSM is in HALT
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic          dbg_halt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} mode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  mode_e       mode_q, mode_d;
  logic [31:0] pc_q;
  logic        resp_valid_q;
  logic [31:0] resp_pc_q;
  logic        resp_inj_q;   // response was injected for a misaligned PC
  entry_t      fifo_q [2];   // fifo_q[0] is the head
  logic [1:0]  count_q;

  logic   can_fetch, issue, inject;
  logic   out_valid, handshake, push, pop;
  entry_t resp_entry, out_entry;

  // Request / handshake decode
  always_comb begin
    can_fetch = !rst && (mode_q == RUN) && (count_q == 2'd0) && !bus.redirect_valid;
    issue     = can_fetch && (pc_q[1:0] == 2'b00);
    // A misaligned PC produces exactly one fault entry: the pc is held,
    // so re-injection is blocked while the injected entry is pending.
    inject    = can_fetch && (pc_q[1:0] != 2'b00) && !resp_valid_q;

    resp_entry.pc    = resp_pc_q;
    resp_entry.fault = resp_inj_q || bus.imem_err;
    resp_entry.inst  = resp_entry.fault ? 32'h0 : bus.imem_rdata;

    out_entry = (count_q != 2'd0) ? fifo_q[0] : resp_entry;
    out_valid = !bus.redirect_valid && ((count_q != 2'd0) || resp_valid_q);
    handshake = out_valid && bus.id_ready;

    pop  = !bus.redirect_valid && (count_q != 2'd0) && bus.id_ready;
    push = !bus.redirect_valid && resp_valid_q && !((count_q == 2'd0) && bus.id_ready);
  end

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (rst) mode_q <= RUN;
    else     mode_q <= mode_d;
  end

  // Mode FSM: next state. Redirect wins over a fault handshake.
  always_comb begin
    mode_d = mode_q;
    if (bus.redirect_valid)                mode_d = RUN;
    else if (handshake && out_entry.fault) mode_d = HALT;
  end

  // Mode FSM and datapath outputs
  always_comb begin
    dbg_halt       = (mode_q == HALT);
    bus.imem_addr  = pc_q;
    bus.imem_stall = !issue;
    bus.if_valid   = out_valid;
    bus.if_pc      = out_valid ? out_entry.pc    : 32'h0;
    bus.if_inst    = out_valid ? out_entry.inst  : 32'h0;
    bus.if_fault   = out_valid ? out_entry.fault : 1'b0;
  end

  // PC, response tracking and skid FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'h0;
      resp_inj_q   <= 1'b0;
      count_q      <= 2'd0;
    end else if (bus.redirect_valid) begin
      // Flush everything; the response in this cycle is dropped and no
      // request is issued, so nothing arrives next cycle either.
      pc_q         <= bus.redirect_target;
      resp_valid_q <= 1'b0;
      resp_inj_q   <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      resp_valid_q <= issue || inject;
      if (issue || inject) begin
        resp_pc_q  <= pc_q;
        resp_inj_q <= inject;
      end
      if (issue) pc_q <= pc_q + 32'd4;

      case ({push, pop})
        2'b10: begin
          fifo_q[count_q[0]] <= resp_entry;
          count_q            <= count_q + 2'd1;
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= resp_entry;
          end else begin
            fifo_q[0] <= resp_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
